// File: rtl/complex_fir_coef_sched.sv
// Coefficient scheduler for the complex FIR.
// Holds two banks of complex taps written by the host. On request it streams one
// bank into the FIR coefficient port. The sample stream is gated so that a reload
// only ever happens between sample frames.
// Ports:
//   axis_aclk, axis_aresetn         clock, async active-low reset
//   cfg_wr_*                        host coefficient write (bank, tap index, data)
//   cfg_load/_load_bank/_num_taps   reload request, bank to stream, taps to stream
//   cfg_err, load_done              one-cycle status pulses
//   busy, active_bank, coef_loaded  scheduler status
//   m_coef_*                        AXI-Stream coefficients to FIR S01
//   s_data_* -> m_data_*            gated sample stream to FIR S00
module complex_fir_coef_sched #(
    parameter int unsigned NUM_TAPS   = 64,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned COEF_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic                    cfg_wr_en,
    input  logic                    cfg_wr_bank,
    input  logic [ADDR_WIDTH-1:0]   cfg_wr_addr,
    input  logic [COEF_WIDTH-1:0]   cfg_wr_data,
    input  logic                    cfg_load,
    input  logic                    cfg_load_bank,
    input  logic [ADDR_WIDTH:0]     cfg_num_taps,
    output logic                    cfg_err,
    output logic                    busy,
    output logic                    active_bank,
    output logic                    coef_loaded,
    output logic                    load_done,
    output logic                    m_coef_tvalid,
    input  logic                    m_coef_tready,
    output logic [COEF_WIDTH-1:0]   m_coef_tdata,
    output logic [COEF_WIDTH/8-1:0] m_coef_tstrb,
    output logic                    m_coef_tlast,
    input  logic                    s_data_tvalid,
    output logic                    s_data_tready,
    input  logic [DATA_WIDTH-1:0]   s_data_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_data_tstrb,
    input  logic                    s_data_tlast,
    output logic                    m_data_tvalid,
    input  logic                    m_data_tready,
    output logic [DATA_WIDTH-1:0]   m_data_tdata,
    output logic [DATA_WIDTH/8-1:0] m_data_tstrb,
    output logic                    m_data_tlast
);

    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
    localparam int unsigned CSTRB_W   = COEF_WIDTH / 8;
    localparam int unsigned MEM_DEPTH = 2 * NUM_TAPS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PREFETCH,
        S_STREAM,
        S_DONE
    } state_e;

    // Coefficient RAM, addressed as {bank, tap}; contents survive reset.
    logic [COEF_WIDTH-1:0] mem [MEM_DEPTH];

    state_e               state_q, state_d;
    logic                 bank_q, bank_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic                 in_frame_q, in_frame_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 busy_q, busy_d;
    logic                 active_bank_q, active_bank_d;
    logic                 coef_loaded_q, coef_loaded_d;
    logic                 load_done_q, load_done_d;
    logic                 coef_tvalid_q, coef_tvalid_d;
    logic                 coef_tlast_q, coef_tlast_d;
    logic [CSTRB_W-1:0]   coef_tstrb_q, coef_tstrb_d;
    logic [COEF_WIDTH-1:0] rd_data_q, rd_data_d;

    logic gate_open;
    logic data_acc;
    logic coef_hs;
    logic num_ok;
    logic wr_blocked;
    logic wr_ok;
    logic load_err;

    // Sample gate: open when idle, or while draining the frame in flight.
    assign gate_open     = (state_q == S_IDLE) || ((state_q == S_DRAIN) && in_frame_q);
    assign m_data_tvalid = s_data_tvalid & gate_open;
    assign s_data_tready = m_data_tready & gate_open;
    assign m_data_tdata  = s_data_tdata;
    assign m_data_tstrb  = s_data_tstrb;
    assign m_data_tlast  = s_data_tlast;
    assign data_acc      = s_data_tvalid & m_data_tready & gate_open;

    assign coef_hs    = coef_tvalid_q & m_coef_tready;
    assign num_ok     = (cfg_num_taps != '0) && (cfg_num_taps <= CNT_W'(NUM_TAPS));
    // The bank being read must not change under the read-ahead.
    assign wr_blocked = ((state_q == S_PREFETCH) || (state_q == S_STREAM)) &&
                        (cfg_wr_bank == bank_q);
    assign wr_ok      = cfg_wr_en & ~wr_blocked;
    assign load_err   = cfg_load & ((state_q != S_IDLE) | ~num_ok);

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        count_d       = count_q;
        idx_d         = idx_q;
        in_frame_d    = in_frame_q;
        rd_data_d     = rd_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_load && num_ok) begin
                    bank_d  = cfg_load_bank;
                    count_d = cfg_num_taps;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!in_frame_q) begin
                    state_d = S_PREFETCH;
                end
            end
            S_PREFETCH: begin
                idx_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (coef_hs) begin
                    idx_d = idx_q + CNT_W'(1);
                    if (coef_tlast_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (data_acc) begin
            in_frame_d = ~s_data_tlast;
        end

        // Read-ahead: fetch the beat that will be presented next cycle; on a stall
        // the same address is re-read, which keeps tdata stable.
        if (state_d == S_STREAM) begin
            rd_data_d = mem[{bank_d, idx_d[ADDR_WIDTH-1:0]}];
        end

        cfg_err_d     = load_err | (cfg_wr_en & wr_blocked);
        busy_d        = (state_d != S_IDLE);
        load_done_d   = (state_d == S_DONE);
        active_bank_d = (state_d == S_DONE) ? bank_q : active_bank_q;
        coef_loaded_d = coef_loaded_q | (state_d == S_DONE);
        coef_tvalid_d = (state_d == S_STREAM);
        coef_tlast_d  = (state_d == S_STREAM) && (idx_d == (count_d - CNT_W'(1)));
        coef_tstrb_d  = (state_d == S_STREAM) ? '1 : '0;
    end

    // State and output registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q       <= S_IDLE;
            bank_q        <= 1'b0;
            count_q       <= '0;
            idx_q         <= '0;
            in_frame_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            active_bank_q <= 1'b0;
            coef_loaded_q <= 1'b0;
            load_done_q   <= 1'b0;
            coef_tvalid_q <= 1'b0;
            coef_tlast_q  <= 1'b0;
            coef_tstrb_q  <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            in_frame_q    <= in_frame_d;
            cfg_err_q     <= cfg_err_d;
            busy_q        <= busy_d;
            active_bank_q <= active_bank_d;
            coef_loaded_q <= coef_loaded_d;
            load_done_q   <= load_done_d;
            coef_tvalid_q <= coef_tvalid_d;
            coef_tlast_q  <= coef_tlast_d;
            coef_tstrb_q  <= coef_tstrb_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Host writes land on the next edge.
    always_ff @(posedge axis_aclk) begin
        if (wr_ok) begin
            mem[{cfg_wr_bank, cfg_wr_addr}] <= cfg_wr_data;
        end
    end

    assign cfg_err       = cfg_err_q;
    assign busy          = busy_q;
    assign active_bank   = active_bank_q;
    assign coef_loaded   = coef_loaded_q;
    assign load_done     = load_done_q;
    assign m_coef_tvalid = coef_tvalid_q;
    assign m_coef_tdata  = rd_data_q;
    assign m_coef_tstrb  = coef_tstrb_q;
    assign m_coef_tlast  = coef_tlast_q;

endmodule

// File: tb/tb_complex_fir_coef_sched.sv
// Self-checking bench for complex_fir_coef_sched.
module tb_complex_fir_coef_sched;

    logic        clk = 1'b0;
    logic        axis_aresetn;
    logic        cfg_wr_en, cfg_wr_bank, cfg_load, cfg_load_bank;
    logic [5:0]  cfg_wr_addr;
    logic [63:0] cfg_wr_data;
    logic [6:0]  cfg_num_taps;
    logic        cfg_err, busy, active_bank, coef_loaded, load_done;
    logic        m_coef_tvalid, m_coef_tready, m_coef_tlast;
    logic [63:0] m_coef_tdata;
    logic [7:0]  m_coef_tstrb;
    logic        s_data_tvalid, s_data_tready, s_data_tlast;
    logic [63:0] s_data_tdata;
    logic [7:0]  s_data_tstrb;
    logic        m_data_tvalid, m_data_tready, m_data_tlast;
    logic [63:0] m_data_tdata;
    logic [7:0]  m_data_tstrb;

    complex_fir_coef_sched dut (
        .axis_aclk(clk), .axis_aresetn(axis_aresetn),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_bank(cfg_wr_bank), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_load(cfg_load), .cfg_load_bank(cfg_load_bank),
        .cfg_num_taps(cfg_num_taps), .cfg_err(cfg_err), .busy(busy),
        .active_bank(active_bank), .coef_loaded(coef_loaded), .load_done(load_done),
        .m_coef_tvalid(m_coef_tvalid), .m_coef_tready(m_coef_tready),
        .m_coef_tdata(m_coef_tdata), .m_coef_tstrb(m_coef_tstrb), .m_coef_tlast(m_coef_tlast),
        .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
        .s_data_tdata(s_data_tdata), .s_data_tstrb(s_data_tstrb), .s_data_tlast(s_data_tlast),
        .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
        .m_data_tdata(m_data_tdata), .m_data_tstrb(m_data_tstrb), .m_data_tlast(m_data_tlast)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Coefficient tready pattern: mode 0 always ready, mode 1 repeats 1,0,0,1.
    int tr_mode = 0;
    int tr_pc   = 0;
    initial m_coef_tready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (tr_mode == 1) begin
            m_coef_tready = ((tr_pc % 4) == 0) || ((tr_pc % 4) == 3);
            tr_pc++;
        end else begin
            m_coef_tready = 1'b1;
        end
    end

    // ---------------- behavioural model ----------------
    logic [63:0] mem_m [0:1][0:63];
    logic [63:0] rec_data [0:63];
    logic        pending, reading, in_frame_m, err_due, done_due;
    logic        active_m, loaded_m, stalled_prev, exp_bank;
    logic [63:0] prev_data;
    int          exp_count, beat, beats_last, done_cyc;
    logic        gate, hs, err_n, last_beat, num_valid;

    always @(negedge clk) begin
        if (!axis_aresetn) begin
            pending = 0; reading = 0; in_frame_m = 0; err_due = 0; done_due = 0;
            active_m = 0; loaded_m = 0; stalled_prev = 0; beat = 0;
        end else begin
            chk("busy", busy, pending);
            chk("cfg_err", cfg_err, err_due);
            chk("load_done", load_done, done_due);
            chk("active_bank", active_bank, active_m);
            chk("coef_loaded", coef_loaded, loaded_m);
            gate = !pending || in_frame_m;
            chk("m_data_tvalid", m_data_tvalid, s_data_tvalid & gate);
            chk("s_data_tready", s_data_tready, m_data_tready & gate);
            chk("m_data_pass", {m_data_tdata[54:0], m_data_tstrb, m_data_tlast},
                {s_data_tdata[54:0], s_data_tstrb, s_data_tlast});
            if (stalled_prev) begin
                chk("coef_hold_valid", m_coef_tvalid, 1);
                chk("coef_hold_data", m_coef_tdata, prev_data);
            end
            if (!reading) chk("coef_tvalid_off", m_coef_tvalid, 0);
            if (reading && m_coef_tvalid && beat < 64) begin
                chk("coef_tdata", m_coef_tdata, mem_m[exp_bank][beat]);
                chk("coef_tlast", m_coef_tlast, beat == exp_count - 1);
                chk("coef_tstrb", m_coef_tstrb, 8'hFF);
            end
            if (load_done) done_cyc = cyc;

            // advance model to the next cycle
            hs        = m_coef_tvalid && m_coef_tready;
            last_beat = hs && reading && (beat == exp_count - 1);
            num_valid = (cfg_num_taps >= 1) && (cfg_num_taps <= 64);
            err_n = (cfg_load && (pending || !num_valid)) ||
                    (cfg_wr_en && reading && (cfg_wr_bank == exp_bank));
            if (cfg_wr_en && !(reading && cfg_wr_bank == exp_bank))
                mem_m[cfg_wr_bank][cfg_wr_addr] = cfg_wr_data;
            if (done_due) pending = 0;
            if (pending && !reading && !done_due && !in_frame_m) reading = 1;
            if (s_data_tvalid && m_data_tready && gate) in_frame_m = !s_data_tlast;
            done_due = last_beat;
            if (last_beat) begin
                reading = 0; active_m = exp_bank; loaded_m = 1; beats_last = beat + 1;
            end
            if (hs && beat < 64) begin
                rec_data[beat] = m_coef_tdata;
                beat++;
            end
            if (cfg_load && !pending && num_valid) begin
                pending = 1; exp_bank = cfg_load_bank; exp_count = int'(cfg_num_taps); beat = 0;
            end
            stalled_prev = m_coef_tvalid && !m_coef_tready;
            prev_data    = m_coef_tdata;
            err_due      = err_n;
        end
    end

    // ---------------- stimulus helpers (enter and leave at posedge+1) ----------------
    task automatic wr(input logic bank, input int addr, input logic [63:0] data);
        cfg_wr_en = 1; cfg_wr_bank = bank; cfg_wr_addr = 6'(addr); cfg_wr_data = data;
        @(posedge clk); #1;
        cfg_wr_en = 0;
    endtask

    task automatic do_load(input logic bank, input int n, input int exp_lat);
        int lat;
        cfg_load = 1; cfg_load_bank = bank; cfg_num_taps = 7'(n);
        @(posedge clk); #1;
        cfg_load = 0;
        if (exp_lat >= 0) begin
            lat = 1;
            while (lat < 50) begin
                @(negedge clk);
                if (m_coef_tvalid) break;
                lat++;
            end
            chk("first_beat_latency", 64'(lat), 64'(exp_lat));
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (load_done) break;
        end
        if (k == 2000) chk("load_done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    int sent_cnt   = 0;
    int frame2_cyc = -1;

    task automatic send_frame(input int n, input int base);
        int k;
        for (int i = 0; i < n; i++) begin
            s_data_tvalid = 1; s_data_tdata = 64'(base + i);
            s_data_tlast = (i == n - 1); s_data_tstrb = 8'hFF;
            for (k = 0; k < 500; k++) begin
                @(negedge clk);
                if (s_data_tready) begin
                    sent_cnt++;
                    if (base == 100 && i == 0) frame2_cyc = cyc;
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (k == 500) chk("sample_accept_timeout", 0, 1);
        end
        s_data_tvalid = 0; s_data_tlast = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        nfail++;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        axis_aresetn = 0;
        cfg_wr_en = 0; cfg_wr_bank = 0; cfg_wr_addr = 0; cfg_wr_data = 0;
        cfg_load = 0; cfg_load_bank = 0; cfg_num_taps = 0;
        s_data_tvalid = 0; s_data_tdata = 0; s_data_tstrb = 0; s_data_tlast = 0;
        m_data_tready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_coef_tvalid", m_coef_tvalid, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        @(posedge clk); #1;
        axis_aresetn = 1;
        @(posedge clk); #1;

        // Full 64-tap load of bank0.
        for (int k = 0; k < 64; k++) wr(0, k, {32'(k), 32'(-k)});
        for (int k = 0; k < 64; k++) wr(1, k, {32'(k + 100), 32'(2 * k)});
        do_load(0, 64, 3);
        wait_done();
        chk("t1_beats", 64'(beats_last), 64);
        chk("t1_beat0", rec_data[0], 64'h0);
        chk("t1_beat63", rec_data[63], 64'h0000003F_FFFFFFC1);
        chk("t1_active_bank", active_bank, 0);
        chk("t1_coef_loaded", coef_loaded, 1);

        // Reload requested mid-frame.
        fork
            begin send_frame(10, 0); send_frame(2, 100); end
            begin
                for (int k = 0; k < 100 && sent_cnt < 3; k++) begin @(posedge clk); #1; end
                do_load(0, 16, -1);
                wait_done();
            end
        join
        chk("t2_reopen_gap", 64'(frame2_cyc - done_cyc), 1);

        // Stalled short load, then illegal tap counts.
        tr_mode = 1;
        do_load(0, 5, 3);
        wait_done();
        tr_mode = 0;
        chk("t3_beats", 64'(beats_last), 5);
        chk("t3_beat4", rec_data[4], 64'h00000004_FFFFFFFC);
        do_load(0, 0, -1);
        @(negedge clk); chk("t3_err0", cfg_err, 1); chk("t3_busy0", busy, 0);
        @(posedge clk); #1;
        do_load(1, 65, -1);
        @(negedge clk); chk("t3_err65", cfg_err, 1); chk("t3_busy65", busy, 0);
        @(posedge clk); #1;

        // Writes during a bank1 stream, load while busy.
        tr_mode = 1;
        do_load(1, 64, 3);
        wr(1, 2, 64'hDEAD_BEEF_DEAD_BEEF);
        @(negedge clk); chk("t4_wr_locked_err", cfg_err, 1);
        @(posedge clk); #1;
        wr(0, 2, 64'h0123_4567_89AB_CDEF);
        @(negedge clk); chk("t4_wr_other_ok", cfg_err, 0);
        @(posedge clk); #1;
        do_load(0, 4, -1);
        @(negedge clk); chk("t4_load_busy_err", cfg_err, 1);
        @(posedge clk); #1;
        wait_done();
        tr_mode = 0;
        do_load(0, 4, 3);
        wait_done();
        chk("t4_bank0_new", rec_data[2], 64'h01234567_89ABCDEF);
        do_load(1, 4, 3);
        wait_done();
        chk("t4_bank1_kept", rec_data[2], 64'h00000066_00000004);
        chk("t4_active_bank", active_bank, 1);

        // Reset in the middle of a stream.
        do_load(1, 64, 3);
        for (int k = 0; k < 200 && beat < 20; k++) begin @(posedge clk); #1; end
        axis_aresetn = 0;
        #1;
        chk("t5_tvalid", m_coef_tvalid, 0);
        chk("t5_tlast", m_coef_tlast, 0);
        chk("t5_tdata", m_coef_tdata, 0);
        chk("t5_busy", busy, 0);
        chk("t5_active_bank", active_bank, 0);
        chk("t5_coef_loaded", coef_loaded, 0);
        chk("t5_load_done", load_done, 0);
        repeat (2) @(posedge clk);
        #1;
        axis_aresetn = 1;
        @(posedge clk); #1;
        do_load(0, 8, 3);
        wait_done();
        chk("t5_beats", 64'(beats_last), 8);
        chk("t5_beat7", rec_data[7], 64'h00000007_FFFFFFF9);
        chk("t5_coef_loaded_after", coef_loaded, 1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/complex_fir_coef_sched.md
Name: complex_fir_coef_sched

Overview:
Coefficient scheduler for the complex FIR. Holds two banks of complex tap coefficients written by the host, streams a selected bank into the FIR coefficient AXI-Stream port (S01), and gates the sample stream (S00 path) so that a reload only ever happens between sample frames. Sits between the host config logic and the FIR, in the FIR clock domain.

Parameters:
NUM_TAPS, 64, maximum taps per bank
ADDR_WIDTH, 6, log2(NUM_TAPS)
COEF_WIDTH, 64, coefficient word {imag[63:32], real[31:0]}
DATA_WIDTH, 64, sample stream width

Ports:
axis_aclk  in  1  single clock for all interfaces
axis_aresetn  in  1  asynchronous active-low reset
cfg_wr_en  in  1  coefficient write strobe
cfg_wr_bank  in  1  bank to write
cfg_wr_addr  in  ADDR_WIDTH  tap index
cfg_wr_data  in  COEF_WIDTH  coefficient
cfg_load  in  1  single-cycle reload request
cfg_load_bank  in  1  bank to stream
cfg_num_taps  in  ADDR_WIDTH+1  taps to stream, 1..NUM_TAPS
cfg_err  out  1  one-cycle error pulse
busy  out  1  state != IDLE
active_bank  out  1  bank last loaded into FIR
coef_loaded  out  1  at least one load has completed
load_done  out  1  one-cycle pulse at end of load
m_coef_tvalid/tready/tdata/tstrb/tlast  out/in/out/out/out  1/1/COEF_WIDTH/COEF_WIDTH/8/1  to FIR S01
s_data_tvalid/tready/tdata/tstrb/tlast  in/out/in/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8/1  from sample source
m_data_tvalid/tready/tdata/tstrb/tlast  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  to FIR S00

Behaviour:
- Reset: state IDLE; all tvalid 0; cfg_err, load_done, busy, active_bank, coef_loaded 0; in_frame 0. RAM contents are not reset.
- RAM: 2 x NUM_TAPS x COEF_WIDTH. A write lands on the next clock edge, with synchronous read.
- Data gate: gate_open = (IDLE) or (DRAIN and in_frame). m_data_tvalid = s_data_tvalid & gate_open. s_data_tready = m_data_tready & gate_open. tdata/tstrb/tlast pass combinationally.
- in_frame: set on an accepted beat with tlast=0. Cleared on an accepted beat with tlast=1.
- FSM states:
  - IDLE:
    - cfg_load with cfg_num_taps in 1..NUM_TAPS latches bank and count, then goes to DRAIN.
    - Otherwise, cfg_load pulses cfg_err and the state stays IDLE.
  - DRAIN:
    - Waits until in_frame=0, so the gate is closed that cycle, then goes to PREFETCH.
    - If in_frame is already 0 on entry, DRAIN lasts 1 cycle.
  - PREFETCH: reads address 0 for 1 cycle, then goes to STREAM.
  - STREAM:
    - m_coef_tvalid=1 with tdata = mem[bank][idx] and tstrb all ones.
    - tlast=1 when idx = count-1.
    - On each handshake idx increments. Read-ahead sustains 1 beat per cycle while tready=1.
    - tvalid/tdata are held stable while tready=0.
    - The handshake on the tlast beat goes to DONE.
  - DONE:
    - Lasts 1 cycle. load_done=1; active_bank <= latched bank; coef_loaded <= 1.
    - Then goes to IDLE, and the gate reopens next cycle.
- cfg_load while busy: ignored, cfg_err pulse.
- cfg_wr_en to the latched bank while in PREFETCH or STREAM: write dropped, cfg_err pulse. Writes to the other bank always succeed.
- A simultaneous write error and load error produce a single cfg_err pulse.
- Latency: idle with no open frame, from cfg_load to first m_coef_tvalid = 3 cycles (DRAIN, PREFETCH, STREAM).
- Reset mid-operation:
  - Immediate return to the reset state. The coefficient stream is truncated with no tlast.
  - active_bank and coef_loaded return to 0.

Test Plan:
- Write bank0 taps k -> {imag=k, real=-k}. Load bank0 with num_taps=64 and tready=1 -> 64 consecutive beats, data matches, tlast only on beat 63, load_done one cycle later, active_bank=0, coef_loaded=1.
- Sample frame of 10 beats in progress when cfg_load arrives at beat 3 -> the remaining 7 beats pass, the gate closes the cycle after tlast, and no sample beat is accepted until 1 cycle after load_done.
- Load with num_taps=5 and tready toggling 1,0,0,1 -> 5 beats, data stable during stalls, tlast on beat 4. num_taps=0 or 65 -> cfg_err pulse, busy stays 0.
- During a bank1 STREAM, write bank1 addr 2 -> cfg_err and the RAM is unchanged. Write bank0 addr 2 -> no error and the value is read back on the next bank0 load. cfg_load while busy -> cfg_err.
- Assert axis_aresetn low at STREAM beat 20 -> all outputs 0 asynchronously. A following load of 8 taps completes normally.
